core_regs: RTL and testbench
============================

Name: core_regs

Overview:
- General-purpose register file: 32 x 32-bit, the write-side endpoint of the execute stage's register write interface (we / write address / write data).
- Provides two read ports to the decode stage plus a committed-state debug read port.
- Storage is cleared after reset by a sequential init sweep, one register per cycle, so the array can map to RAM-style storage without a parallel reset.
- Includes write-to-read bypass; x0 is hardwired to zero.

Parameters:
REG_NUM, 32, number of architectural registers (power of two)
ADDR_W, 5, register address width, log2(REG_NUM)
DATA_W, 32, register data width

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
reg_we_in  in  1  write enable from execute stage
reg_write_addr_in  in  ADDR_W  write register index
reg_write_data_in  in  DATA_W  write data
reg1_re_in  in  1  read port 1 enable
reg1_addr_in  in  ADDR_W  read port 1 index
reg2_re_in  in  1  read port 2 enable
reg2_addr_in  in  ADDR_W  read port 2 index
reg1_data_out  out  DATA_W  read port 1 data (combinational)
reg2_data_out  out  DATA_W  read port 2 data (combinational)
dbg_addr_in  in  ADDR_W  debug read index
dbg_data_out  out  DATA_W  debug read data, committed contents only
init_done_out  out  1  high once init sweep is complete
write_count_out  out  32  number of committed writes since reset, excluding x0 and dropped writes

Behaviour:
- Reset: the only reset is the synchronous, active-high rst sampled on the clk edge.
  - On that edge: state <= INIT, sweep_ptr <= 0, init_done_out <= 0, write_count_out <= 0.
- Read ports and the debug port are combinational. While rst is high or state is INIT, all read outputs are 0.
- FSM INIT:
  - Each clk edge with rst low writes 0 to reg[sweep_ptr] and increments sweep_ptr.
  - On the edge that clears reg[REG_NUM-1]: state <= RUN, init_done_out <= 1.
  - Init therefore takes exactly REG_NUM (32) cycles after rst deasserts.
  - Writes from the execute stage during INIT are dropped and not counted.
- FSM RUN:
  - Stays in RUN until rst. No other transitions.
- Write, RUN only:
  - On the clk edge with reg_we_in=1 and reg_write_addr_in!=0: reg[addr] <= reg_write_data_in and write_count_out increments by 1.
  - write_count_out wraps modulo 2^32.
  - A write to x0 is ignored and not counted.
- Read port n, RUN only:
  - If regn_re_in=0, output 0.
  - Else if regn_addr_in==0, output 0.
  - Else if reg_we_in=1 and reg_write_addr_in==regn_addr_in, output reg_write_data_in (same-cycle bypass, write-first).
  - Otherwise output reg[regn_addr_in].
- Both read ports may address the same register or the write register at the same time; each port resolves independently by the rules above.
- Debug port: outputs reg[dbg_addr_in] in RUN, 0 in INIT, and 0 for index 0. It never bypasses, so it reflects committed state only.
- Reset mid-operation:
  - rst during INIT or RUN aborts the current state and restarts the sweep from index 0 on the next low cycle.
  - All contents become 0 again after the 32-cycle sweep.
  - A write presented on the same edge as rst is dropped.
- Widths: addresses are used unsigned, with no truncation since REG_NUM = 2^ADDR_W. Data is passed bit-exact with no sign handling.

Test Plan:
- Release rst, sample init_done_out each cycle -> low for cycles 0..31, high from cycle 32; dbg reads of x1..x31 return 0; a write to x5=0xDEADBEEF at cycle 10 is dropped (dbg x5 = 0, write_count_out = 0).
- After init, write x3=0x12345678 -> the next cycle reg1 (re=1, addr=3) reads 0x12345678; write_count_out = 1; with reg1_re_in=0 reg1 reads 0.
- Same cycle: we=1, addr=7, data=0xA5A5A5A5 with reg1_addr=7 and reg2_addr=7 -> both read ports show 0xA5A5A5A5 combinationally; dbg x7 shows the old value (0) until the edge.
- Write x0=0xFFFFFFFF -> reg1 addr 0 reads 0, the bypass is suppressed, dbg x0 = 0, and write_count_out is unchanged.
- Fill x1..x31 with the value index*0x01010101, then assert rst for 1 cycle at random -> init_done_out drops; after 32 cycles all registers read 0 and write_count_out = 0.
- Preload write_count_out near wrap by issuing 2^32-1 writes (or force the counter in simulation), then one more write -> write_count_out reads 0.

Source files
------------

// File: rtl/core_regs.sv
// core_regs: 32x32 register file with init sweep, write-first bypass, x0 hardwired to zero
// and a committed-state debug port.
module core_regs #(
    parameter int REG_NUM = 32,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_we_in,
    input  logic [ADDR_W-1:0] reg_write_addr_in,
    input  logic [DATA_W-1:0] reg_write_data_in,
    input  logic              reg1_re_in,
    input  logic [ADDR_W-1:0] reg1_addr_in,
    input  logic              reg2_re_in,
    input  logic [ADDR_W-1:0] reg2_addr_in,
    output logic [DATA_W-1:0] reg1_data_out,
    output logic [DATA_W-1:0] reg2_data_out,
    input  logic [ADDR_W-1:0] dbg_addr_in,
    output logic [DATA_W-1:0] dbg_data_out,
    output logic              init_done_out,
    output logic [31:0]       write_count_out
);
    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] sweep_ptr;
    logic [DATA_W-1:0] mem [REG_NUM];
    logic              run;
    logic              commit;

    assign run    = state == RUN && !rst;
    assign commit = run && reg_we_in && reg_write_addr_in != '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= INIT;
            sweep_ptr       <= '0;
            init_done_out   <= 1'b0;
            write_count_out <= '0;
        end else if (state == INIT) begin
            sweep_ptr <= sweep_ptr + 1'b1;
            if (sweep_ptr == ADDR_W'(REG_NUM - 1)) begin
                state         <= RUN;
                init_done_out <= 1'b1;
            end
        end else if (commit) begin
            write_count_out <= write_count_out + 32'd1;
        end
    end

    // Storage has no reset of its own so it can map onto RAM; the sweep clears it.
    always_ff @(posedge clk) begin
        if (!rst && state == INIT)
            mem[sweep_ptr] <= '0;
        else if (commit)
            mem[reg_write_addr_in] <= reg_write_data_in;
    end

    always_comb begin
        reg1_data_out = (!run || !reg1_re_in || reg1_addr_in == '0) ? '0 :
                        (reg_we_in && reg_write_addr_in == reg1_addr_in) ? reg_write_data_in :
                        mem[reg1_addr_in];
        reg2_data_out = (!run || !reg2_re_in || reg2_addr_in == '0) ? '0 :
                        (reg_we_in && reg_write_addr_in == reg2_addr_in) ? reg_write_data_in :
                        mem[reg2_addr_in];
        dbg_data_out  = (!run || dbg_addr_in == '0) ? '0 : mem[dbg_addr_in];
    end
endmodule

// File: tb/tb_core_regs.sv
// tb_core_regs: directed checks of init sweep, writes, bypass, x0, reset and counter wrap.
module tb_core_regs;
    logic        clk = 1'b0;
    logic        rst;
    logic        reg_we_in;
    logic [4:0]  reg_write_addr_in;
    logic [31:0] reg_write_data_in;
    logic        reg1_re_in;
    logic [4:0]  reg1_addr_in;
    logic        reg2_re_in;
    logic [4:0]  reg2_addr_in;
    logic [31:0] reg1_data_out;
    logic [31:0] reg2_data_out;
    logic [4:0]  dbg_addr_in;
    logic [31:0] dbg_data_out;
    logic        init_done_out;
    logic [31:0] write_count_out;

    int n_chk = 0;
    int n_fail = 0;

    core_regs dut (
        .clk(clk), .rst(rst),
        .reg_we_in(reg_we_in), .reg_write_addr_in(reg_write_addr_in), .reg_write_data_in(reg_write_data_in),
        .reg1_re_in(reg1_re_in), .reg1_addr_in(reg1_addr_in),
        .reg2_re_in(reg2_re_in), .reg2_addr_in(reg2_addr_in),
        .reg1_data_out(reg1_data_out), .reg2_data_out(reg2_data_out),
        .dbg_addr_in(dbg_addr_in), .dbg_data_out(dbg_data_out),
        .init_done_out(init_done_out), .write_count_out(write_count_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        reg_we_in = 1'b1;
        reg_write_addr_in = a;
        reg_write_data_in = d;
    endtask

    initial begin
        rst = 1'b1;
        reg_we_in = 1'b0; reg_write_addr_in = '0; reg_write_data_in = '0;
        reg1_re_in = 1'b1; reg1_addr_in = 5'd1;
        reg2_re_in = 1'b1; reg2_addr_in = 5'd2;
        dbg_addr_in = 5'd1;
        step; step;
        check("rst_init_done", {31'd0, init_done_out}, 32'd0);
        check("rst_count", write_count_out, 32'd0);
        check("rst_reg1", reg1_data_out, 32'd0);

        // Sweep: init_done low for 32 cycles after release; write at cycle 10 is dropped.
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int c = 0; c <= 40; c++) begin
            check($sformatf("init_done_c%0d", c), {31'd0, init_done_out}, (c >= 32) ? 32'd1 : 32'd0);
            if (c == 10) begin
                wr(5'd5, 32'hDEADBEEF);
                reg1_addr_in = 5'd5;
                #1;
                check("init_reg1_zero", reg1_data_out, 32'd0);
            end
            step;
            reg_we_in = 1'b0;
        end
        for (int i = 1; i < 32; i++) begin
            dbg_addr_in = 5'(i);
            #1;
            check($sformatf("post_init_dbg_x%0d", i), dbg_data_out, 32'd0);
        end
        check("dropped_count", write_count_out, 32'd0);

        // Plain write then read.
        wr(5'd3, 32'h12345678);
        reg1_addr_in = 5'd3;
        step;
        reg_we_in = 1'b0;
        #1;
        check("x3_read", reg1_data_out, 32'h12345678);
        check("count_1", write_count_out, 32'd1);
        reg1_re_in = 1'b0;
        #1;
        check("x3_re0", reg1_data_out, 32'd0);
        reg1_re_in = 1'b1;

        // Same-cycle bypass on both ports; debug shows committed value only.
        wr(5'd7, 32'hA5A5A5A5);
        reg1_addr_in = 5'd7; reg2_addr_in = 5'd7; dbg_addr_in = 5'd7;
        #1;
        check("byp_reg1", reg1_data_out, 32'hA5A5A5A5);
        check("byp_reg2", reg2_data_out, 32'hA5A5A5A5);
        check("byp_dbg_old", dbg_data_out, 32'd0);
        step;
        reg_we_in = 1'b0;
        #1;
        check("x7_dbg", dbg_data_out, 32'hA5A5A5A5);
        check("count_2", write_count_out, 32'd2);

        // x0 write ignored, never bypassed.
        wr(5'd0, 32'hFFFFFFFF);
        reg1_addr_in = 5'd0; reg2_addr_in = 5'd0; dbg_addr_in = 5'd0;
        #1;
        check("x0_reg1", reg1_data_out, 32'd0);
        check("x0_reg2", reg2_data_out, 32'd0);
        step;
        reg_we_in = 1'b0;
        #1;
        check("x0_dbg", dbg_data_out, 32'd0);
        check("x0_count", write_count_out, 32'd2);

        // Fill x1..x31 with index*0x01010101.
        for (int i = 1; i < 32; i++) begin
            wr(5'(i), 32'(i) * 32'h01010101);
            step;
        end
        reg_we_in = 1'b0;
        dbg_addr_in = 5'd31; reg2_addr_in = 5'd17; reg1_addr_in = 5'd3;
        #1;
        check("fill_dbg_x31", dbg_data_out, 32'h1F1F1F1F);
        check("fill_reg2_x17", reg2_data_out, 32'h11111111);
        check("fill_reg1_x3", reg1_data_out, 32'h03030303);
        check("fill_count", write_count_out, 32'd33);

        // One-cycle reset at a random point, with a write on the same edge.
        repeat ($urandom_range(0, 5)) step;
        rst = 1'b1;
        wr(5'd4, 32'h00000077);
        #1;
        check("rst_hi_reg1", reg1_data_out, 32'd0);
        check("rst_hi_dbg", dbg_data_out, 32'd0);
        step;
        rst = 1'b0;
        reg_we_in = 1'b0;
        #1;
        check("rerst_init_done", {31'd0, init_done_out}, 32'd0);
        check("rerst_count", write_count_out, 32'd0);
        repeat (31) step;
        check("rerst_c31", {31'd0, init_done_out}, 32'd0);
        step;
        check("rerst_c32", {31'd0, init_done_out}, 32'd1);
        for (int i = 1; i < 32; i++) begin
            dbg_addr_in = 5'(i);
            reg1_addr_in = 5'(i);
            #1;
            check($sformatf("rerst_dbg_x%0d", i), dbg_data_out, 32'd0);
            check($sformatf("rerst_reg1_x%0d", i), reg1_data_out, 32'd0);
        end
        check("rerst_count_after", write_count_out, 32'd0);

        // Counter wrap via force.
        force dut.write_count_out = 32'hFFFFFFFF;
        #1;
        release dut.write_count_out;
        #1;
        check("wrap_pre", write_count_out, 32'hFFFFFFFF);
        wr(5'd9, 32'h00000001);
        dbg_addr_in = 5'd9;
        step;
        reg_we_in = 1'b0;
        #1;
        check("wrap_count", write_count_out, 32'd0);
        check("wrap_dbg_x9", dbg_data_out, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
